// File: rtl/reg_bank_sequencer.sv
// Control sequencer for the register bank: steps one ARMv4 instruction through operand gating, result latch and PC increment.
// Optional macro COND_EXEC_EN adds an NZCV input and evaluates the condition field at accept time.
module reg_bank_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        IR_VALID,
    input  logic [31:0] IR,
`ifdef COND_EXEC_EN
    input  logic [3:0]  NZCV,
`endif
    output logic        IR_READY,
    output logic        LATCH_REG,
    output logic        PC_MUX,
    output logic        RD_MUX,
    output logic        DATA_MUX,
    output logic        REG_GATE_A,
    output logic        REG_GATE_B,
    output logic        REG_GATE_C,
    output logic        INSTR_DONE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_MUL1  = 3'd2,
        S_MUL2  = 3'd3,
        S_PCINC = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    logic ready_c, latch_c, pc_mux_c, rd_mux_c, data_mux_c;
    logic gate_a_c, gate_b_c, gate_c_c, done_c;
    logic cond_ok;
    logic unused_ir_bits;

    assign unused_ir_bits = ^{ir_q[31:28], ir_q[20:16], ir_q[11:8], ir_q[3:0]};

`ifdef COND_EXEC_EN
    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = NZCV;

    always_comb begin
        cond_ok = 1'b0;
        case (IR[31:28])
            4'h0: cond_ok = flag_z;
            4'h1: cond_ok = ~flag_z;
            4'h2: cond_ok = flag_c;
            4'h3: cond_ok = ~flag_c;
            4'h4: cond_ok = flag_n;
            4'h5: cond_ok = ~flag_n;
            4'h6: cond_ok = flag_v;
            4'h7: cond_ok = ~flag_v;
            4'h8: cond_ok = flag_c & ~flag_z;
            4'h9: cond_ok = ~flag_c | flag_z;
            4'hA: cond_ok = (flag_n == flag_v);
            4'hB: cond_ok = (flag_n != flag_v);
            4'hC: cond_ok = ~flag_z & (flag_n == flag_v);
            4'hD: cond_ok = flag_z | (flag_n != flag_v);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end
`else
    assign cond_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ready_c    = 1'b0;
        latch_c    = 1'b0;
        pc_mux_c   = 1'b0;
        rd_mux_c   = 1'b0;
        data_mux_c = 1'b0;
        gate_a_c   = 1'b0;
        gate_b_c   = 1'b0;
        gate_c_c   = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_c = 1'b1;
                if (IR_VALID) begin
                    ir_d = IR;
                    // Class decode runs on the port word so the first execute cycle follows the accept edge directly.
                    if (!cond_ok)
                        state_d = S_PCINC;
                    else if (IR[27:22] == 6'b000000 && IR[7:4] == 4'b1001)
                        state_d = S_MUL1;
                    else if (IR[27:26] == 2'b00)
                        state_d = S_EXEC;
                    else
                        state_d = S_PCINC;
                end
            end
            S_EXEC: begin
                rd_mux_c   = 1'b1;
                data_mux_c = 1'b1;
                gate_a_c   = ~(ir_q[24:21] == 4'b1101 || ir_q[24:21] == 4'b1111);
                gate_b_c   = ~ir_q[25];
                gate_c_c   = ~ir_q[25] & ir_q[4];
                latch_c    = (ir_q[24:23] != 2'b10);
                // A write to R15 already redirects the PC, so the increment step is skipped.
                if (latch_c && ir_q[15:12] == 4'hF) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PCINC;
                end
            end
            S_MUL1, S_MUL2: begin
                gate_a_c   = ir_q[21];
                gate_b_c   = 1'b1;
                gate_c_c   = 1'b1;
                data_mux_c = 1'b1;
                latch_c    = (state_q == S_MUL2);
                state_d    = (state_q == S_MUL1) ? S_MUL2 : S_PCINC;
            end
            S_PCINC: begin
                pc_mux_c = 1'b1;
                latch_c  = 1'b1;
                done_c   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every control line is held low while reset is asserted, including the cycle an abandoned sequence is in.
    assign IR_READY   = ready_c    & ~rst;
    assign LATCH_REG  = latch_c    & ~rst;
    assign PC_MUX     = pc_mux_c   & ~rst;
    assign RD_MUX     = rd_mux_c   & ~rst;
    assign DATA_MUX   = data_mux_c & ~rst;
    assign REG_GATE_A = gate_a_c   & ~rst;
    assign REG_GATE_B = gate_b_c   & ~rst;
    assign REG_GATE_C = gate_c_c   & ~rst;
    assign INSTR_DONE = done_c     & ~rst;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Self-checking bench for reg_bank_sequencer: directed vector table, reset corner cases and randomized instructions.
module tb_reg_bank_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        IR_VALID;
    logic [31:0] IR;
    logic [3:0]  NZCV;
    logic        IR_READY, LATCH_REG, PC_MUX, RD_MUX, DATA_MUX;
    logic        REG_GATE_A, REG_GATE_B, REG_GATE_C, INSTR_DONE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .IR_VALID   (IR_VALID),
        .IR         (IR),
`ifdef COND_EXEC_EN
        .NZCV       (NZCV),
`endif
        .IR_READY   (IR_READY),
        .LATCH_REG  (LATCH_REG),
        .PC_MUX     (PC_MUX),
        .RD_MUX     (RD_MUX),
        .DATA_MUX   (DATA_MUX),
        .REG_GATE_A (REG_GATE_A),
        .REG_GATE_B (REG_GATE_B),
        .REG_GATE_C (REG_GATE_C),
        .INSTR_DONE (INSTR_DONE)
    );

    // {IR_READY, LATCH_REG, PC_MUX, RD_MUX, DATA_MUX, A, B, C, INSTR_DONE}
    logic [8:0] outs;
    assign outs = {IR_READY, LATCH_REG, PC_MUX, RD_MUX, DATA_MUX,
                   REG_GATE_A, REG_GATE_B, REG_GATE_C, INSTR_DONE};

    localparam logic [8:0] V_IDLE  = 9'h100;
    localparam logic [8:0] V_PCINC = 9'h0C1;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [3:0]  nzcv;
        bit          hold;
        int          exp_cycles;
        logic [8:0]  exp_first;
    } vec_t;

    logic [8:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: list of per-cycle control words following the accept edge.
    task automatic build_expected(input logic [31:0] ir, input logic [3:0] f);
        bit is_mul, is_dp, a, b, c, wr, fin;
        logic [3:0] op;
        exp_q.delete();
        is_mul = (ir[27:22] == 6'd0) && (ir[7:4] == 4'd9);
        is_dp  = (ir[27:26] == 2'd0) && !is_mul;
`ifdef COND_EXEC_EN
        if (!cond_pass(ir[31:28], f)) begin
            is_mul = 1'b0;
            is_dp  = 1'b0;
        end
`endif
        if (is_mul) begin
            exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ir[21], 1'b1, 1'b1, 1'b0});
            exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ir[21], 1'b1, 1'b1, 1'b0});
            exp_q.push_back(V_PCINC);
        end else if (is_dp) begin
            op  = ir[24:21];
            a   = !(op == 4'd13 || op == 4'd15);
            b   = !ir[25];
            c   = !ir[25] && ir[4];
            wr  = !(op >= 4'd8 && op <= 4'd11);
            fin = wr && (ir[15:12] == 4'd15);
            exp_q.push_back({1'b0, wr, 1'b0, 1'b1, 1'b1, a, b, c, fin});
            if (!fin) exp_q.push_back(V_PCINC);
        end else begin
            exp_q.push_back(V_PCINC);
        end
    endtask

    // Issues one instruction from IDLE and compares every cycle up to and including INSTR_DONE.
    task automatic run_instr(input string name, input logic [31:0] ir, input logic [3:0] f,
                             input bit hold, output int ncyc, output logic [8:0] first);
        logic [8:0] e;
        ncyc  = 0;
        first = 9'h0;
        check({name, "_idle_before"}, {23'd0, outs}, {23'd0, V_IDLE});
        build_expected(ir, f);
        IR       = ir;
        NZCV     = f;
        IR_VALID = 1'b1;
        tick();
        if (!hold) IR_VALID = 1'b0;
        IR   = $urandom;
        NZCV = 4'($urandom);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) first = outs;
            e = (i < exp_q.size()) ? exp_q[i] : V_IDLE;
            check($sformatf("%s_cyc%0d", name, i + 1), {23'd0, outs}, {23'd0, e});
            if (outs[0] === 1'b1) begin
                ncyc = i + 1;
                break;
            end
            tick();
        end
        tick();
        IR_VALID = 1'b0;
        check({name, "_idle_after"}, {23'd0, outs}, {23'd0, V_IDLE});
    endtask

    vec_t vecs[$];

    initial begin
        int         n;
        logic [8:0] first;
        logic [31:0] r;
        logic [3:0]  fl;

        rst = 1'b1; IR_VALID = 1'b0; IR = 32'd0; NZCV = 4'd0;
        vecs.push_back('{"add",      32'hE0885001, 4'h0, 1'b0, 2, 9'h0BC});
        vecs.push_back('{"mul",      32'hE00E0297, 4'h0, 1'b0, 3, 9'h016});
        vecs.push_back('{"mla",      32'hE02E3297, 4'h0, 1'b0, 3, 9'h01E});
        vecs.push_back('{"cmp",      32'hE1510002, 4'h0, 1'b0, 2, 9'h03C});
        vecs.push_back('{"mov_pc",   32'hE1A0F00E, 4'h0, 1'b0, 1, 9'h0B5});
        vecs.push_back('{"ldr",      32'hE5912000, 4'h0, 1'b1, 1, 9'h0C1});
        vecs.push_back('{"add_rsh",  32'hE0810312, 4'h0, 1'b0, 2, 9'h0BE});
        vecs.push_back('{"mov_imm",  32'hE3A00005, 4'h0, 1'b1, 2, 9'h0B0});
        vecs.push_back('{"tst_r15",  32'hE110F000, 4'h0, 1'b0, 2, 9'h03C});
        vecs.push_back('{"mul_r15",  32'hE00F0291, 4'h0, 1'b1, 3, 9'h016});
`ifdef COND_EXEC_EN
        vecs.push_back('{"addeq_f",  32'h00885001, 4'h0, 1'b0, 1, 9'h0C1});
        vecs.push_back('{"addeq_t",  32'h00885001, 4'h4, 1'b0, 2, 9'h0BC});
        vecs.push_back('{"mul_nv",   32'hF00E0297, 4'hF, 1'b0, 1, 9'h0C1});
`endif

        // Reset held for two cycles.
        tick();
        check("rst_outs_c1", {23'd0, outs}, 32'd0);
        tick();
        check("rst_outs_c2", {23'd0, outs}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release", {23'd0, outs}, {23'd0, V_IDLE});

        foreach (vecs[k]) begin
            run_instr(vecs[k].name, vecs[k].ir, vecs[k].nzcv, vecs[k].hold, n, first);
            check({vecs[k].name, "_first"}, {23'd0, first}, {23'd0, vecs[k].exp_first});
            check({vecs[k].name, "_len"}, n, vecs[k].exp_cycles);
        end

        // Reset asserted during MUL1 abandons the multiply.
        IR = 32'hE02E3297; IR_VALID = 1'b1;
        tick();
        IR_VALID = 1'b0;
        check("mul1_before_rst", {23'd0, outs}, 32'h01E);
        rst = 1'b1;
        #1;
        check("rst_in_mul1", {23'd0, outs}, 32'd0);
        tick();
        check("rst_after_mul1", {23'd0, outs}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_mul_idle", {23'd0, outs}, {23'd0, V_IDLE});
        tick();
        check("rst_mul_stays_idle", {23'd0, outs}, {23'd0, V_IDLE});

        // Randomized instructions biased toward the supported classes.
        for (int t = 0; t < 200; t++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: r[27:22] = 6'd0;
                1: begin r[27:22] = {5'd0, r[22]}; r[7:4] = 4'b1001; end
                2: r[27:26] = 2'b00;
                default: ;
            endcase
`ifndef COND_EXEC_EN
            if ($urandom_range(0, 1) == 0) r[31:28] = 4'hE;
`endif
            fl = 4'($urandom);
            run_instr($sformatf("rnd%0d", t), r, fl, 1'($urandom), n, first);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
